// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR command scheduler.
package ddr_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StHold,
        StWait
    } state_e;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0] is the read client, req[1] the write client.
module rr_arb2
    import ddr_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Holds CMD_RD or CMD_WR for the client granted most recently.
    logic last_grant_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant_q == CMD_WR) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= CMD_WR;
        end else if (update && (grant != 2'b00)) begin
            last_grant_q <= grant[1];
        end
    end

endmodule

// File: rtl/ddr_cmd_sched.sv
// Arbitrates read/write clients, splits each request into MAX_CHUNK-sized mover
// commands and waits for the mover to go idle between chunks.
module ddr_cmd_sched
    import ddr_sched_pkg::*;
#(
    parameter int unsigned C_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_AXI_DATA_WIDTH = 256,
    parameter int unsigned SINGLE_LEN       = 24,
    parameter int unsigned MAX_CHUNK        = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init_cmptd,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [SINGLE_LEN-1:0]       rd_req_len,
    output logic                        rd_done,
    input  logic                        wr_req_valid,
    output logic                        wr_req_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [SINGLE_LEN-1:0]       wr_req_len,
    output logic                        wr_done,
    output logic [C_AXI_ADDR_WIDTH-1:0] ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]       ddr_len,
    output logic                        ddr_conf,
    output logic                        cmd_type,
    input  logic                        dp_idle,
    output logic                        busy
);

    localparam int unsigned           BeatBytes = beat_bytes(C_AXI_DATA_WIDTH);
    localparam logic [SINGLE_LEN-1:0] LenMask   = ~SINGLE_LEN'(BeatBytes - 1);
    localparam logic [SINGLE_LEN-1:0] MaxChunk  = SINGLE_LEN'(MAX_CHUNK);

    state_e                      state_q, state_d;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d, src_addr;
    logic [SINGLE_LEN-1:0]       rem_q, rem_d, src_rem, chunk;
    logic                        type_q, type_d, src_type;
    logic [1:0]                  arb_req, grant;
    logic                        handshake;
    logic                        conf_d, rd_done_d, wr_done_d;

    assign arb_req = (!rst && (state_q == StIdle) && init_cmptd && dp_idle) ?
                     {wr_req_valid, rd_req_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .update (handshake),
        .grant  (grant)
    );

    assign rd_req_ready = grant[0];
    assign wr_req_ready = grant[1];
    assign handshake    = |grant;

    always_comb begin
        // Source of the next chunk: the fresh request on handshake, else the latched remainder.
        src_addr = addr_q;
        src_rem  = rem_q;
        src_type = type_q;
        if (handshake) begin
            src_addr = grant[1] ? wr_req_addr : rd_req_addr;
            src_rem  = (grant[1] ? wr_req_len : rd_req_len) & LenMask;
            src_type = grant[1] ? CMD_WR : CMD_RD;
        end
        chunk = (src_rem < MaxChunk) ? src_rem : MaxChunk;

        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        type_d    = type_q;
        rd_done_d = 1'b0;
        wr_done_d = 1'b0;

        if (!init_cmptd) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (handshake) begin
                        addr_d = src_addr;
                        rem_d  = src_rem;
                        type_d = src_type;
                        if (src_rem == '0) begin
                            rd_done_d = (src_type == CMD_RD);
                            wr_done_d = (src_type == CMD_WR);
                        end else begin
                            state_d = StIssue;
                        end
                    end
                end
                StIssue: state_d = StHold;
                StHold:  state_d = StWait;
                StWait: begin
                    if (dp_idle) begin
                        if (rem_q != '0) begin
                            state_d = StIssue;
                        end else begin
                            state_d   = StIdle;
                            rd_done_d = (type_q == CMD_RD);
                            wr_done_d = (type_q == CMD_WR);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Outputs are registered, so the chunk is consumed on the edge that enters ISSUE.
        conf_d = (state_d == StIssue);
        if (conf_d) begin
            addr_d = src_addr + C_AXI_ADDR_WIDTH'(chunk);
            rem_d  = src_rem - chunk;
            type_d = src_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            rem_q           <= '0;
            type_q          <= CMD_RD;
            ddr_conf        <= 1'b0;
            rd_done         <= 1'b0;
            wr_done         <= 1'b0;
            busy            <= 1'b0;
            ddr_st_addr_out <= '0;
            ddr_len         <= '0;
            cmd_type        <= CMD_RD;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            type_q   <= type_d;
            ddr_conf <= conf_d;
            rd_done  <= rd_done_d;
            wr_done  <= wr_done_d;
            busy     <= (state_d != StIdle);
            if (conf_d) begin
                ddr_st_addr_out <= src_addr;
                ddr_len         <= chunk;
                cmd_type        <= src_type;
            end
        end
    end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Bench for ddr_cmd_sched: directed and random requests against a chunk-list model.
module tb_ddr_cmd_sched;

    localparam int AW   = 64;
    localparam int LW   = 24;
    localparam int BEAT = 32;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_cmptd = 1'b0;
    logic          rd_req_valid = 1'b0;
    logic          wr_req_valid = 1'b0;
    logic [AW-1:0] rd_req_addr = '0;
    logic [AW-1:0] wr_req_addr = '0;
    logic [LW-1:0] rd_req_len = '0;
    logic [LW-1:0] wr_req_len = '0;
    logic          dp_idle = 1'b1;
    logic          rd_req_ready, wr_req_ready, rd_done, wr_done, ddr_conf, cmd_type, busy;
    logic [AW-1:0] ddr_st_addr_out;
    logic [LW-1:0] ddr_len;

    ddr_cmd_sched dut (
        .clk             (clk),
        .rst             (rst),
        .init_cmptd      (init_cmptd),
        .rd_req_valid    (rd_req_valid),
        .rd_req_ready    (rd_req_ready),
        .rd_req_addr     (rd_req_addr),
        .rd_req_len      (rd_req_len),
        .rd_done         (rd_done),
        .wr_req_valid    (wr_req_valid),
        .wr_req_ready    (wr_req_ready),
        .wr_req_addr     (wr_req_addr),
        .wr_req_len      (wr_req_len),
        .wr_done         (wr_done),
        .ddr_st_addr_out (ddr_st_addr_out),
        .ddr_len         (ddr_len),
        .ddr_conf        (ddr_conf),
        .cmd_type        (cmd_type),
        .dp_idle         (dp_idle),
        .busy            (busy)
    );

    bit clk_en = 1'b1;
    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic          typ;
        int            cyc;
    } conf_t;

    conf_t conf_q[$];
    conf_t exp_q[$];
    int    rd_done_q[$];
    int    wr_done_q[$];
    bit    busy_seen = 1'b0;
    int    last_conf = -100;
    int    min_gap = 1000;

    always @(negedge clk) begin
        if (ddr_conf) begin
            conf_q.push_back('{ddr_st_addr_out, ddr_len, cmd_type, cyc});
            if (cyc - last_conf < min_gap) min_gap = cyc - last_conf;
            last_conf = cyc;
        end
        if (rd_done) rd_done_q.push_back(cyc);
        if (wr_done) wr_done_q.push_back(cyc);
        if (busy) busy_seen = 1'b1;
    end

    // Mover model: goes busy the cycle after a command and idles mover_lat cycles later.
    int mover_lat = 20;
    int rise_cyc = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (ddr_conf) begin
            @(posedge clk);
            #1;
            dp_idle = 1'b0;
            repeat (mover_lat) @(posedge clk);
            #1;
            dp_idle = 1'b1;
            rise_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        conf_q.delete();
        exp_q.delete();
        rd_done_q.delete();
        wr_done_q.delete();
        busy_seen = 1'b0;
        last_conf = -100;
        min_gap = 1000;
    endtask

    // Reference: the chunk list a request must produce, from plain arithmetic.
    task automatic model(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic typ);
        longint unsigned rem;
        longint unsigned c;
        logic [AW-1:0]   p;
        rem = longint'(l) - (longint'(l) % BEAT);
        p = a;
        while (rem > 0) begin
            c = (rem > MAXC) ? MAXC : rem;
            exp_q.push_back('{p, LW'(c), typ, 0});
            p = p + c;
            rem = rem - c;
        end
    endtask

    task automatic cmp_confs(input string tag);
        chk({tag, "_count"}, conf_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < conf_q.size(); i++) begin
            chk({tag, "_addr"}, conf_q[i].addr, exp_q[i].addr);
            chk({tag, "_len"}, conf_q[i].len, exp_q[i].len);
            chk({tag, "_type"}, conf_q[i].typ, exp_q[i].typ);
        end
    endtask

    task automatic request(input logic is_wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           output int hs);
        int b;
        b = 0;
        @(negedge clk);
        if (is_wr) begin
            wr_req_valid = 1'b1;
            wr_req_addr = a;
            wr_req_len = l;
        end else begin
            rd_req_valid = 1'b1;
            rd_req_addr = a;
            rd_req_len = l;
        end
        #1;
        while (!(is_wr ? wr_req_ready : rd_req_ready) && b < 2000) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk("handshake", is_wr ? wr_req_ready : rd_req_ready, 1);
        hs = cyc;
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
    endtask

    task automatic wait_done(input logic is_wr, input int target);
        int b;
        b = 0;
        while ((is_wr ? wr_done_q.size() : rd_done_q.size()) < target && b < 3000) begin
            @(negedge clk);
            #1;
            b++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_conf"}, ddr_conf, 0);
        chk({tag, "_rd_done"}, rd_done, 0);
        chk({tag, "_wr_done"}, wr_done, 0);
        chk({tag, "_addr"}, ddr_st_addr_out, 0);
        chk({tag, "_len"}, ddr_len, 0);
        chk({tag, "_type"}, cmd_type, 0);
        chk({tag, "_rd_ready"}, rd_req_ready, 0);
        chk({tag, "_wr_ready"}, wr_req_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            hs;
        int            b;
        int            n_rd;
        int            n_wr;
        int            order[$];
        logic [AW-1:0] ra, wa, a;
        logic [LW-1:0] l;
        logic          typ;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        init_cmptd = 1'b1;

        // Single-chunk read with a slow mover
        clear_obs();
        mover_lat = 20;
        model(64'h1000, 256, 1'b0);
        request(1'b0, 64'h1000, 256, hs);
        wait_done(1'b0, 1);
        cmp_confs("rd256");
        chk("rd256_conf_cyc", conf_q[0].cyc, hs + 1);
        chk("rd256_done_n", rd_done_q.size(), 1);
        chk("rd256_done_cyc", rd_done_q[0], rise_cyc + 1);

        // Three-chunk write
        clear_obs();
        mover_lat = 5;
        model(64'h0, 10240, 1'b1);
        request(1'b1, 64'h0, 10240, hs);
        wait_done(1'b1, 1);
        cmp_confs("wr10k");
        chk("wr10k_done_n", wr_done_q.size(), 1);
        chk("wr10k_done_cyc", wr_done_q[0], rise_cyc + 1);
        chk("wr10k_no_rd_done", rd_done_q.size(), 0);
        chk("wr10k_gap", min_gap >= 3, 1);

        // Both clients valid every cycle: grants alternate, read first
        clear_obs();
        mover_lat = 3;
        ra = {32'h0, $urandom} << 5;
        wa = {32'h0, $urandom} << 5;
        @(posedge clk);
        #1;
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        rd_req_addr = ra;
        wr_req_addr = wa;
        rd_req_len = 64;
        wr_req_len = 64;
        b = 0;
        while (order.size() < 4 && b < 2000) begin
            @(negedge clk);
            #1;
            b++;
            if (rd_req_ready) order.push_back(0);
            if (wr_req_ready) order.push_back(1);
        end
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        chk("rr_grants", order.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", order[i], i % 2);
        wait_done(1'b0, 2);
        wait_done(1'b1, 2);
        for (int i = 0; i < 4; i++) model((i % 2 == 0) ? ra : wa, 64, 1'(i % 2));
        cmp_confs("rr");
        chk("rr_gap", min_gap >= 3, 1);

        // Randomized requests against the chunk model
        clear_obs();
        n_rd = 0;
        n_wr = 0;
        for (int i = 0; i < 6; i++) begin
            typ = 1'($urandom_range(0, 1));
            a = {32'h0, $urandom};
            l = LW'($urandom_range(0, 13000));
            mover_lat = $urandom_range(1, 6);
            model(a, l, typ);
            request(typ, a, l, hs);
            if (typ) begin
                n_wr++;
                wait_done(1'b1, n_wr);
            end else begin
                n_rd++;
                wait_done(1'b0, n_rd);
            end
        end
        cmp_confs("rnd");
        chk("rnd_rd_done_n", rd_done_q.size(), n_rd);
        chk("rnd_wr_done_n", wr_done_q.size(), n_wr);
        chk("rnd_gap", min_gap >= 3, 1);

        // Sub-beat lengths complete immediately without a command
        clear_obs();
        request(1'b0, 64'h2000, 0, hs);
        wait_done(1'b0, 1);
        chk("len0_done_cyc", rd_done_q[0], hs + 1);
        request(1'b0, 64'h2000, 31, hs);
        wait_done(1'b0, 2);
        chk("len31_done_cyc", rd_done_q[1], hs + 1);
        repeat (3) @(negedge clk);
        chk("short_no_conf", conf_q.size(), 0);
        chk("short_busy", busy_seen, 0);

        // Calibration lost in WAIT, same cycle as the mover idles: abort wins
        clear_obs();
        mover_lat = 2;
        request(1'b1, 64'h8000, 8192, hs);
        while (cyc < hs + 4) @(negedge clk);
        #1;
        chk("abort_busy_before", busy, 1);
        init_cmptd = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_busy_after", busy, 0);
        rd_req_valid = 1'b1;
        #1;
        chk("abort_ready_gated", rd_req_ready, 0);
        rd_req_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_conf_n", conf_q.size(), 1);
        chk("abort_no_wr_done", wr_done_q.size(), 0);
        init_cmptd = 1'b1;
        request(1'b0, 64'h40, 64, hs);
        wait_done(1'b0, 1);
        chk("abort_resume_conf_n", conf_q.size(), 2);
        chk("abort_resume_addr", conf_q[1].addr, 64'h40);
        chk("abort_resume_len", conf_q[1].len, 64);
        chk("abort_resume_type", conf_q[1].typ, 0);

        // Asynchronous reset during ISSUE with the clock stopped
        clear_obs();
        mover_lat = 4;
        request(1'b1, 64'h3000, 4096, hs);
        @(negedge clk);
        chk("arst_in_issue", ddr_conf, 1);
        clk_en = 1'b0;
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        rd_req_addr = 64'h5000;
        wr_req_addr = 64'h6000;
        rd_req_len = 64;
        wr_req_len = 64;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst");
        #5;
        rst = 1'b0;
        #1;
        chk("arst_tie_rd", rd_req_ready, 1);
        chk("arst_tie_wr", wr_req_ready, 0);
        clear_obs();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        wait_done(1'b0, 1);
        model(64'h5000, 64, 1'b0);
        cmp_confs("arst_rd");
        chk("arst_no_wr_done", wr_done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
